// File: rtl/ram_prod_param.sv
// Word store for UART setup bytes with registered reads and a
// sequential product engine feeding the pulse-timing logic.
module ram_prod_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int OUT_W  = 32,
  parameter int PROD_N = 4
) (
  input  logic              clk_RAM,
  input  logic              rst_RAM,
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic              write,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic              read,
  input  logic              drt_start,
  output logic [OUT_W-1:0]  out,
  output logic              out_valid,
  output logic [OUT_W-1:0]  drt,
  output logic              drt_valid,
  output logic              drt_busy,
  output logic              drt_ovf
);

  localparam int P_W = OUT_W + DATA_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PROD_L =
    (ADDR_W+1)'(PROD_N);
  localparam logic [ADDR_W-1:0] IDX_LAST =
    ADDR_W'(PROD_N - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE =
    ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state;
  logic              pending;
  logic [ADDR_W-1:0] idx;
  logic [OUT_W-1:0]  acc;
  logic              ovf;

  logic              wr_ok;
  logic              rd_ok;
  logic              trig;
  logic [P_W-1:0]    prod;

  assign wr_ok = write &&
    ({1'b0, w_addr} < DEPTH_L);
  assign rd_ok =
    ({1'b0, r_addr} < DEPTH_L);
  assign trig = drt_start ||
    (wr_ok && ({1'b0, w_addr} < PROD_L));

  assign drt_busy = (state != S_IDLE);

  always_comb begin
    prod = P_W'(acc) * P_W'(mem[idx]);
  end

  // Read-first: out samples the word before
  // any write landing on the same edge.
  always_ff @(posedge clk_RAM) begin
    if (rst_RAM) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= read;
      if (read)
        out <= rd_ok ?
          OUT_W'(mem[r_addr]) : '0;
      if (wr_ok)
        mem[w_addr] <= in;
    end
  end

  // Triggers seen while busy collapse into one
  // recompute; a trigger during DONE restarts at once.
  always_ff @(posedge clk_RAM) begin
    if (rst_RAM) begin
      state     <= S_IDLE;
      pending   <= 1'b0;
      idx       <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      drt       <= '0;
      drt_ovf   <= 1'b0;
      drt_valid <= 1'b0;
    end else begin
      drt_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (trig)
            state <= S_LOAD;
        end
        S_LOAD: begin
          acc   <= OUT_W'(mem[0]);
          ovf   <= 1'b0;
          idx   <= IDX_ONE;
          state <= S_MUL;
          if (trig)
            pending <= 1'b1;
        end
        S_MUL: begin
          acc <= prod[OUT_W-1:0];
          ovf <= ovf | (|prod[P_W-1:OUT_W]);
          idx <= idx + IDX_ONE;
          if (idx == IDX_LAST)
            state <= S_DONE;
          if (trig)
            pending <= 1'b1;
        end
        S_DONE: begin
          drt       <= acc;
          drt_ovf   <= ovf;
          drt_valid <= 1'b1;
          pending   <= 1'b0;
          state     <= (pending || trig) ?
            S_LOAD : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_prod_param.sv
// Bench for ram_prod_param: directed steps plus random
// traffic against a word-array / product reference model.
module tb_ram_prod_param;

  localparam int DEPTH  = 8;
  localparam int PROD_N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic [2:0]  w_addr = '0;
  logic        write = 1'b0;
  logic [2:0]  r_addr = '0;
  logic        read = 1'b0;
  logic        start = 1'b0;
  logic [31:0] out;
  logic        out_valid;
  logic [31:0] drt;
  logic        drt_valid;
  logic        drt_busy;
  logic        drt_ovf;

  logic [15:0] din16 = '0;
  logic [2:0]  w_addr16 = '0;
  logic        write16 = 1'b0;
  logic [31:0] out16;
  logic        out_valid16;
  logic [31:0] drt16;
  logic        drt_valid16;
  logic        drt_busy16;
  logic        drt_ovf16;

  ram_prod_param dut (
    .clk_RAM(clk), .rst_RAM(rst),
    .in(din), .w_addr(w_addr), .write(write),
    .r_addr(r_addr), .read(read),
    .drt_start(start),
    .out(out), .out_valid(out_valid),
    .drt(drt), .drt_valid(drt_valid),
    .drt_busy(drt_busy), .drt_ovf(drt_ovf)
  );

  ram_prod_param #(.DATA_W(16)) dut16 (
    .clk_RAM(clk), .rst_RAM(rst),
    .in(din16), .w_addr(w_addr16),
    .write(write16),
    .r_addr(3'd0), .read(1'b0),
    .drt_start(1'b0),
    .out(out16), .out_valid(out_valid16),
    .drt(drt16), .drt_valid(drt_valid16),
    .drt_busy(drt_busy16), .drt_ovf(drt_ovf16)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_dv   = 0;

  // Reference model: word array, pass position,
  // per-position snapshots of the sampled words.
  longint unsigned mm [DEPTH];
  longint unsigned snap [PROD_N];
  int          ph = -1;
  bit          pend = 1'b0;
  logic [31:0] e_out = '0;
  logic        e_ov = 1'b0;
  logic [31:0] e_drt = '0;
  logic        e_dv = 1'b0;
  logic        e_dovf = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h",
                tag, got, exp);
  endtask

  task automatic model_step();
    bit trig;
    longint unsigned a, p;
    bit o;
    if (rst) begin
      foreach (mm[i]) mm[i] = 0;
      ph = -1; pend = 0;
      e_out = '0; e_ov = 0;
      e_drt = '0; e_dv = 0; e_dovf = 0;
      return;
    end
    trig = start ||
      (write && (w_addr < PROD_N));
    e_dv = 0;
    if (ph == -1) begin
      if (trig) ph = 0;
    end else if (ph < PROD_N) begin
      snap[ph] = mm[ph];
      ph++;
      if (trig) pend = 1;
    end else begin
      a = snap[0]; o = 0;
      for (int k = 1; k < PROD_N; k++) begin
        p = a * snap[k];
        if ((p >> 32) != 0) o = 1;
        a = p & 64'hFFFF_FFFF;
      end
      e_drt = a[31:0]; e_dovf = o; e_dv = 1;
      ph = (pend || trig) ? 0 : -1;
      pend = 0;
    end
    e_ov = read;
    if (read)
      e_out = (r_addr < DEPTH) ?
        32'(mm[r_addr]) : 32'd0;
    if (write && w_addr < DEPTH)
      mm[w_addr] = longint'(din);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    if (drt_valid) n_dv++;
    chk("out", out, e_out);
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("drt", drt, e_drt);
    chk("drt_valid", 32'(drt_valid), 32'(e_dv));
    chk("drt_ovf", 32'(drt_ovf), 32'(e_dovf));
    chk("drt_busy", 32'(drt_busy),
        32'(ph != -1));
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (drt_busy && k < max) begin
      cyc(); k++;
    end
    chk("idle_timeout", 32'(drt_busy), 32'd0);
  endtask

  task automatic wait_idle16(input int max);
    int k = 0;
    while (drt_busy16 && k < max) begin
      cyc(); k++;
    end
    chk("idle16_timeout", 32'(drt_busy16), 32'd0);
  endtask

  initial begin
    longint unsigned a, p;
    bit o;

    cyc(); cyc();
    chk("rst_drt", drt, 32'd0);
    rst = 1'b0;

    read = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      r_addr = 3'(i);
      cyc();
      chk("rst_word", out, 32'd0);
    end
    read = 1'b0;

    write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_addr = 3'(i); din = 8'(i + 2);
      cyc();
    end
    write = 1'b0;
    wait_idle(40);
    chk("prod120", drt, 32'd120);
    chk("prod120_ovf", 32'(drt_ovf), 32'd0);

    write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_addr = 3'(i); din = 8'hFF;
      cyc();
    end
    write = 1'b0;
    wait_idle(40);
    chk("prod255", drt, 32'hFC05FC01);
    chk("prod255_ovf", 32'(drt_ovf), 32'd0);

    write = 1'b1; w_addr = 3'd5; din = 8'd9;
    read = 1'b1; r_addr = 3'd5;
    cyc();
    chk("rw_same_old", out, 32'd0);
    write = 1'b0;
    cyc();
    chk("rw_same_new", out, 32'd9);
    chk("rw_no_busy", 32'(drt_busy), 32'd0);
    read = 1'b0;

    start = 1'b1; cyc();
    start = 1'b0; cyc();
    n_dv = 0;
    start = 1'b1;
    cyc(); cyc(); cyc();
    start = 1'b0;
    wait_idle(40);
    chk("collapse_pulses", 32'(n_dv), 32'd2);

    start = 1'b1; cyc();
    start = 1'b0; cyc(); cyc();
    chk("pre_rst_busy", 32'(drt_busy), 32'd1);
    rst = 1'b1; cyc();
    rst = 1'b0;
    chk("abort_idle", 32'(drt_busy), 32'd0);
    chk("abort_drt", drt, 32'd0);
    n_dv = 0;
    read = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      r_addr = 3'(i);
      cyc();
    end
    read = 1'b0;
    chk("abort_no_pulse", 32'(n_dv), 32'd0);

    for (int i = 0; i < 400; i++) begin
      write  = ($urandom % 3) == 0;
      w_addr = 3'($urandom);
      din    = ($urandom % 5 == 0) ?
        8'd0 : 8'($urandom);
      read   = $urandom % 2;
      r_addr = 3'($urandom);
      start  = ($urandom % 12) == 0;
      cyc();
    end
    write = 1'b0; read = 1'b0; start = 1'b0;
    wait_idle(40);

    write16 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_addr16 = 3'(i); din16 = 16'hFFFF;
      cyc();
    end
    write16 = 1'b0;
    wait_idle16(40);
    a = 64'hFFFF; o = 0;
    for (int k = 1; k < 4; k++) begin
      p = a * 64'hFFFF;
      if ((p >> 32) != 0) o = 1;
      a = p & 64'hFFFF_FFFF;
    end
    chk("w16_drt", drt16, a[31:0]);
    chk("w16_ovf", 32'(drt_ovf16), 32'(o));

    write16 = 1'b1; w_addr16 = 3'd3;
    din16 = 16'h0000;
    cyc();
    write16 = 1'b0;
    wait_idle16(40);
    chk("w16_zero_drt", drt16, 32'd0);
    chk("w16_zero_ovf", 32'(drt_ovf16), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
